fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 136 +++++++++++++
 tb/tb_fetch_stage.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, talks to a combinational program
// memory, and fills the IF/ID pipeline register. A BOOT/RUN/HALT machine
// gates fetching. Any misaligned or out-of-range PC load parks the stage in HALT.
module fetch_stage #(
    parameter logic [31:0] RESET_PC     = 32'h0040_0000,
    parameter int          MEMORY_DEPTH = 32,
    parameter int          DATA_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [DATA_WIDTH-1:0] branch_target,
    input  logic                  jump,
    input  logic [DATA_WIDTH-1:0] jump_target,
    input  logic                  jr,
    input  logic [DATA_WIDTH-1:0] jr_target,
    input  logic [DATA_WIDTH-1:0] imem_instr,
    output logic [DATA_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] if_id_instr,
    output logic [DATA_WIDTH-1:0] if_id_pc_plus4,
    output logic                  if_id_valid,
    output logic                  fetch_error
);

    localparam logic [DATA_WIDTH-1:0] RESET_ADDR = DATA_WIDTH'(RESET_PC);
    localparam logic [DATA_WIDTH-1:0] DEPTH_W    = DATA_WIDTH'(MEMORY_DEPTH);
    localparam logic [DATA_WIDTH-1:0] STEP       = DATA_WIDTH'(4);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0] pcPlus4_q, pcPlus4_d;
    logic                  valid_q, valid_d;
    logic                  error_q, error_d;

    logic [DATA_WIDTH-1:0] pcPlus4;
    logic [DATA_WIDTH-1:0] nextTarget;
    logic [DATA_WIDTH-1:0] targetOffset;
    logic                  redirectReq;
    logic                  loadPc;
    logic                  targetBad;

    // Pick the address that would load into the PC this cycle and judge it
    always_comb begin
        pcPlus4      = pc_q + STEP;
        redirectReq  = jr | jump | branch_taken;
        if (jr) begin
            nextTarget = jr_target;
        end else if (jump) begin
            nextTarget = jump_target;
        end else if (branch_taken) begin
            nextTarget = branch_target;
        end else begin
            nextTarget = pcPlus4;
        end
        loadPc       = redirectReq | ~stall;
        targetOffset = nextTarget - RESET_ADDR;
        targetBad    = (nextTarget[1:0] != 2'b00) ||
                       (nextTarget < RESET_ADDR) ||
                       ((targetOffset >> 2) >= DEPTH_W);
    end

    // Next-state logic: redirect beats stall, and HALT freezes everything
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        pcPlus4_d = pcPlus4_q;
        valid_d   = valid_q;
        error_d   = error_q;
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (loadPc) begin
                    pc_d = nextTarget;
                    if (targetBad) begin
                        state_d = HALT;
                        error_d = 1'b1;
                        instr_d = '0;
                        valid_d = 1'b0;
                    end else if (redirectReq) begin
                        instr_d = '0;
                        valid_d = 1'b0;
                    end else begin
                        instr_d   = imem_instr;
                        pcPlus4_d = pcPlus4;
                        valid_d   = 1'b1;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // State and pipeline register update with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= BOOT;
            pc_q      <= RESET_ADDR;
            instr_q   <= '0;
            pcPlus4_q <= '0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            pcPlus4_q <= pcPlus4_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
        end
    end

    assign imem_addr      = pc_q - RESET_ADDR;
    assign pc             = pc_q;
    assign if_id_instr    = instr_q;
    assign if_id_pc_plus4 = pcPlus4_q;
    assign if_id_valid    = valid_q;
    assign fetch_error    = error_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a small ROM model feeds the DUT, each step
// pushes its expected register contents to a scoreboard, and the entry is
// popped and checked one time unit after the clock edge.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        jr;
    logic [31:0] jr_target;
    logic [31:0] imem_instr;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        fetch_error;

    logic [31:0] rom [0:31];

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pcPlus4;
        logic        valid;
        logic        err;
    } expect_t;

    expect_t sb[$];
    int assertCount = 0;
    int failCount   = 0;

    fetch_stage #(
        .RESET_PC    (RESET_PC),
        .MEMORY_DEPTH(32),
        .DATA_WIDTH  (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .jr            (jr),
        .jr_target     (jr_target),
        .imem_instr    (imem_instr),
        .imem_addr     (imem_addr),
        .pc            (pc),
        .if_id_instr   (if_id_instr),
        .if_id_pc_plus4(if_id_pc_plus4),
        .if_id_valid   (if_id_valid),
        .fetch_error   (fetch_error)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    // Combinational program memory; addresses outside the ROM read a marker
    always_comb begin
        if (imem_addr < 32'd128) begin
            imem_instr = rom[imem_addr[6:2]];
        end else begin
            imem_instr = 32'hDEAD_BEEF;
        end
    end

    // Safety net so the run can never hang
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkField(input string tag, input string field,
                              input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s.%s observed=%h expected=%h", tag, field, observed, expected);
        end
    endtask

    task automatic checkOutput();
        expect_t e;
        assertCount++;
        assert (sb.size() != 0) else begin
            failCount++;
            $error("[TB] FAIL scoreboard observed=empty expected=entry");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checkField(e.tag, "pc", pc, e.pc);
            checkField(e.tag, "imem_addr", imem_addr, e.pc - RESET_PC);
            checkField(e.tag, "if_id_instr", if_id_instr, e.instr);
            checkField(e.tag, "if_id_pc_plus4", if_id_pc_plus4, e.pcPlus4);
            checkField(e.tag, "if_id_valid", {31'd0, if_id_valid}, {31'd0, e.valid});
            checkField(e.tag, "fetch_error", {31'd0, fetch_error}, {31'd0, e.err});
        end
    endtask

    // Drive one cycle of inputs, queue what the registers must hold after
    // the next edge, then clock and check
    task automatic applyStimulus(
        input string tag,
        input logic rstN, input logic stl,
        input logic br, input logic [31:0] brT,
        input logic jp, input logic [31:0] jpT,
        input logic jrr, input logic [31:0] jrT,
        input logic [31:0] ePc, input logic [31:0] eInstr,
        input logic [31:0] eP4, input logic eValid, input logic eErr);
        expect_t e;
        reset         = rstN;
        stall         = stl;
        branch_taken  = br;
        branch_target = brT;
        jump          = jp;
        jump_target   = jpT;
        jr            = jrr;
        jr_target     = jrT;
        e.tag     = tag;
        e.pc      = ePc;
        e.instr   = eInstr;
        e.pcPlus4 = eP4;
        e.valid   = eValid;
        e.err     = eErr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            rom[i] = 32'hA000_0000 | 32'(i);
        end
        rom[0] = 32'h11;
        rom[1] = 32'h22;
        rom[2] = 32'h33;
        rom[3] = 32'h44;
        reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        jump = 1'b0; jump_target = '0; jr = 1'b0; jr_target = '0;
        #2;

        // Reset, then boot, then sequential fetch
        applyStimulus("reset0", 0, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0000, 0, 0, 0, 0);
        applyStimulus("reset1", 0, 1, 1, 32'h0040_0010, 0, 0, 0, 0, 32'h0040_0000, 0, 0, 0, 0);
        applyStimulus("boot", 1, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0000, 0, 0, 0, 0);
        applyStimulus("fetch0", 1, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0004, 32'h11, 32'h0040_0004, 1, 0);
        applyStimulus("fetch1", 1, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0008, 32'h22, 32'h0040_0008, 1, 0);

        // Two stalled cycles hold everything, then word 2 is fetched
        applyStimulus("stall0", 1, 1, 0, 0, 0, 0, 0, 0, 32'h0040_0008, 32'h22, 32'h0040_0008, 1, 0);
        applyStimulus("stall1", 1, 1, 0, 0, 0, 0, 0, 0, 32'h0040_0008, 32'h22, 32'h0040_0008, 1, 0);
        applyStimulus("resume", 1, 0, 0, 0, 0, 0, 0, 0, 32'h0040_000C, 32'h33, 32'h0040_000C, 1, 0);

        // Jump beats branch and stall; then fetch at the jump target
        applyStimulus("jumpOverBr", 1, 1, 1, 32'h0040_0010, 1, 32'h0040_0040, 0, 0,
                      32'h0040_0040, 0, 32'h0040_000C, 0, 0);
        applyStimulus("fetchJ", 1, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0044, 32'hA000_0010, 32'h0040_0044, 1, 0);

        // JR beats jump
        applyStimulus("jrOverJump", 1, 0, 0, 0, 1, 32'h0040_0040, 1, 32'h0040_0020,
                      32'h0040_0020, 0, 32'h0040_0044, 0, 0);
        applyStimulus("fetchJr", 1, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0024, 32'hA000_0008, 32'h0040_0024, 1, 0);

        // Target below RESET_PC faults
        applyStimulus("faultLow", 1, 0, 0, 0, 1, 32'h003F_FFFC, 0, 0,
                      32'h003F_FFFC, 0, 32'h0040_0024, 0, 1);
        applyStimulus("rstFromHalt", 0, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0000, 0, 0, 0, 0);
        applyStimulus("boot2", 1, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0000, 0, 0, 0, 0);

        // Misaligned branch target faults; HALT ignores later jr and fetch
        applyStimulus("faultAlign", 1, 0, 1, 32'h0040_0006, 0, 0, 0, 0,
                      32'h0040_0006, 0, 0, 0, 1);
        applyStimulus("haltJr", 1, 0, 0, 0, 0, 0, 1, 32'h0040_0000, 32'h0040_0006, 0, 0, 0, 1);
        applyStimulus("haltIdle", 1, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0006, 0, 0, 0, 1);
        applyStimulus("rst2", 0, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0000, 0, 0, 0, 0);
        applyStimulus("boot3", 1, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0000, 0, 0, 0, 0);

        // Last valid word, stalled there (no fault), then pc+4 overruns
        applyStimulus("jumpLast", 1, 0, 0, 0, 1, 32'h0040_007C, 0, 0, 32'h0040_007C, 0, 0, 0, 0);
        applyStimulus("stallLast", 1, 1, 0, 0, 0, 0, 0, 0, 32'h0040_007C, 0, 0, 0, 0);
        applyStimulus("faultRange", 1, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0080, 0, 0, 0, 1);
        applyStimulus("haltJump", 1, 1, 0, 0, 1, 32'h0040_0000, 0, 0, 32'h0040_0080, 0, 0, 0, 1);

        // Reset wins over stall and redirect; redirect ignored in BOOT
        applyStimulus("rst3", 0, 1, 0, 0, 1, 32'h0040_0040, 0, 0, 32'h0040_0000, 0, 0, 0, 0);
        applyStimulus("bootJump", 1, 0, 0, 0, 1, 32'h0040_0040, 0, 0, 32'h0040_0000, 0, 0, 0, 0);
        applyStimulus("fetchAfter", 1, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0004, 32'h11, 32'h0040_0004, 1, 0);

        // Reset mid-stall
        applyStimulus("rstStall", 0, 1, 0, 0, 0, 0, 0, 0, 32'h0040_0000, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
